// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// Imported by the divider and by the execute stage that decodes div ops.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [6:0] DIV_ITER_64 = 7'd64;
  localparam logic [6:0] DIV_ITER_32 = 7'd32;

  function automatic logic [63:0] sext32(
    input logic [31:0] v
  );
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] fin_res(
    input logic [63:0] v,
    input logic        word
  );
    return word ? sext32(v[31:0]) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider for the RV64M div/rem group.
// One quotient bit per cycle; special cases resolve without iterating.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic            is_signed_i,
  input  logic            is_word_i,
  input  logic            is_rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  div_state_e      state_q;
  logic [6:0]      cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            word_q;
  logic            sel_rem_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            a_neg;
  logic            b_neg;
  logic            special;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] min_v;
  logic [XLEN-1:0] spec_q;
  logic [XLEN-1:0] spec_r;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] calc_res;

  // Operand preparation and the no-iteration special cases.
  always_comb begin
    a_ext = dividend_i;
    b_ext = divisor_i;
    if (is_word_i) begin
      a_ext = is_signed_i ? sext32(dividend_i[31:0])
                          : {32'b0, dividend_i[31:0]};
      b_ext = is_signed_i ? sext32(divisor_i[31:0])
                          : {32'b0, divisor_i[31:0]};
    end
    a_neg = is_signed_i & a_ext[XLEN-1];
    b_neg = is_signed_i & b_ext[XLEN-1];
    a_abs = a_neg ? -a_ext : a_ext;
    b_abs = b_neg ? -b_ext : b_ext;
    min_v = is_word_i ? 64'hFFFF_FFFF_8000_0000
                      : 64'h8000_0000_0000_0000;
    spec_q  = a_ext;
    spec_r  = '0;
    special = 1'b0;
    if (b_ext == '0) begin
      spec_q  = '1;
      spec_r  = a_ext;
      special = 1'b1;
    end else if (is_signed_i && a_ext == min_v && (&b_ext)) begin
      special = 1'b1;
    end
    spec_res = fin_res(is_rem_i ? spec_r : spec_q, is_word_i);
  end

  // One compare-subtract step plus sign fix-up of its outcome.
  always_comb begin
    r_sh  = {rem_q, quo_q[XLEN-1]};
    diff  = r_sh - {1'b0, dvs_q};
    ge    = ~diff[XLEN];
    rem_d = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], ge};
    q_fin = qneg_q ? -quo_d : quo_d;
    r_fin = rneg_q ? -rem_d : rem_d;
    calc_res = fin_res(sel_rem_q ? r_fin : q_fin, word_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      word_q    <= 1'b0;
      sel_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush_i) begin
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start_i) begin
            busy_q    <= 1'b1;
            word_q    <= is_word_i;
            sel_rem_q <= is_rem_i;
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            if (special) begin
              result_q <= spec_res;
              done_q   <= 1'b1;
              state_q  <= DIV_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= is_word_i ? (a_abs << 32) : a_abs;
              dvs_q   <= b_abs;
              cnt_q   <= is_word_i ? DIV_ITER_32 : DIV_ITER_64;
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            result_q <= calc_res;
            done_q   <= 1'b1;
            state_q  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed table, random ops vs a
// plain-arithmetic model, and flush/reset mid-operation sequences.
module tb_div_iter;

  logic        clock;
  logic        reset;
  logic        start_i;
  logic        is_signed_i;
  logic        is_word_i;
  logic        is_rem_i;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;

  int checks;
  int failures;

  div_iter #(.XLEN(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_i     (start_i),
    .is_signed_i (is_signed_i),
    .is_word_i   (is_word_i),
    .is_rem_i    (is_rem_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          s;
    bit          w;
    bit          r;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_res;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [63:0] model(input bit s, input bit w,
                                        input bit r,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    int          sa, sb;
    logic [31:0] q32, r32;
    longint      la, lb;
    logic [63:0] q64, r64;
    if (w) begin
      sa = a[31:0];
      sb = b[31:0];
      if (b[31:0] == 32'd0) begin
        q32 = '1;
        r32 = a[31:0];
      end else if (s && a[31:0] == 32'h8000_0000 &&
                   b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0];
        r32 = '0;
      end else if (s) begin
        q32 = sa / sb;
        r32 = sa % sb;
      end else begin
        q32 = a[31:0] / b[31:0];
        r32 = a[31:0] % b[31:0];
      end
      return r ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    la = a;
    lb = b;
    if (b == 64'd0) begin
      q64 = '1;
      r64 = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a;
      r64 = '0;
    end else if (s) begin
      q64 = la / lb;
      r64 = la % lb;
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return r ? r64 : q64;
  endfunction

  function automatic int model_lat(input bit s, input bit w,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    if (w) begin
      if (b[31:0] == 32'd0) return 1;
      if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h0000_0000_8000_0000;
      4: v = 64'(($urandom_range(1, 20)));
      5: v = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  task automatic drive(input bit s, input bit w, input bit r,
                       input logic [63:0] a, input logic [63:0] b);
    start_i     = 1'b1;
    is_signed_i = s;
    is_word_i   = w;
    is_rem_i    = r;
    dividend_i  = a;
    divisor_i   = b;
  endtask

  // Called #1 after an edge with the divider idle; returns result and
  // number of cycles from acceptance to done_o.
  task automatic run_op(input string tag, input bit s, input bit w,
                        input bit r, input logic [63:0] a,
                        input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    drive(s, w, r, a, b);
    @(posedge clock); #1;
    start_i = 1'b0;
    dividend_i = $urandom;
    chk({tag, "_busy_t1"}, 64'(busy_o), 64'd1);
    lat = 1;
    while (!done_o && lat < 150) begin
      @(posedge clock); #1;
      lat++;
    end
    res = result_o;
    chk({tag, "_busy_done"}, 64'(busy_o), 64'd1);
    @(posedge clock); #1;
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_idle_done"}, 64'(done_o), 64'd0);
  endtask

  vec_t        vt[$];
  logic [63:0] res;
  logic [63:0] prev;
  int          lat;
  bit          saw_done;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    flush_i = 1'b0;
    drive(0, 0, 0, 64'd0, 64'd0);
    start_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    vt.push_back('{0, 0, 0, 64'd100, 64'd7, 64'd14, 65});
    vt.push_back('{0, 0, 1, 64'd100, 64'd7, 64'd2, 65});
    vt.push_back('{1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFD, 65});
    vt.push_back('{1, 0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFF, 65});
    vt.push_back('{1, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vt.push_back('{0, 0, 1, 64'd5, 64'd0, 64'd5, 1});
    vt.push_back('{1, 0, 0, 64'h8000_0000_0000_0000, '1,
                   64'h8000_0000_0000_0000, 1});
    vt.push_back('{1, 0, 1, 64'h8000_0000_0000_0000, '1, 64'd0, 1});
    vt.push_back('{1, 1, 0, 64'h0000_0000_8000_0000, '1,
                   64'hFFFF_FFFF_8000_0000, 1});
    vt.push_back('{0, 1, 0, 64'h1234_5678_FFFF_FFFE, 64'd1,
                   64'hFFFF_FFFF_FFFF_FFFE, 33});
    vt.push_back('{0, 1, 1, 64'd7, 64'd0, 64'd7, 1});
    vt.push_back('{1, 1, 1, 64'hFFFF_FFF9, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFF, 33});

    foreach (vt[i]) begin
      run_op($sformatf("vec%0d", i), vt[i].s, vt[i].w, vt[i].r,
             vt[i].a, vt[i].b, res, lat);
      chk($sformatf("vec%0d_res", i), res, vt[i].exp_res);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
    end

    for (int i = 0; i < 40; i++) begin
      bit s, w, r;
      logic [63:0] a, b;
      s = 1'($urandom);
      w = 1'($urandom);
      r = 1'($urandom);
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d", i), s, w, r, a, b, res, lat);
      chk($sformatf("rnd%0d_res", i), res, model(s, w, r, a, b));
      chk($sformatf("rnd%0d_lat", i), 64'(lat),
          64'(model_lat(s, w, a, b)));
    end

    // Flush at T+10, restart at T+11, done expected 65 cycles later.
    prev = result_o;
    drive(0, 0, 0, 64'd100, 64'd7);
    @(posedge clock); #1;
    start_i = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      if (done_o) saw_done = 1'b1;
    end
    flush_i = 1'b1;
    @(posedge clock); #1;
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'd0);
    chk("flush_done", 64'(done_o | saw_done), 64'd0);
    chk("flush_result_held", result_o, prev);
    run_op("post_flush", 0, 0, 0, 64'd100, 64'd7, res, lat);
    chk("post_flush_res", res, 64'd14);
    chk("post_flush_lat", 64'(lat), 64'd65);

    // Same sequence with reset in place of flush.
    drive(0, 0, 1, 64'd100, 64'd7);
    @(posedge clock); #1;
    start_i = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clock); #1;
      if (done_o) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_done", 64'(done_o | saw_done), 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    run_op("post_rst", 0, 0, 1, 64'd100, 64'd7, res, lat);
    chk("post_rst_res", res, 64'd2);
    chk("post_rst_lat", 64'(lat), 64'd65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
